// File: rtl/partial_sum_sequencer_pkg.sv
// Shared definitions for the partial-sum sequencer.
//
// Contents:
//   seqState_t - sequencer FSM state encoding (IDLE, ACCUM, HOLD)
//   cntWidth() - chunk counter width: $clog2(numChunks), never below 1 bit
package partial_sum_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } seqState_t;

  // A single-chunk build still needs a 1-bit counter so the port widths stay legal.
  function automatic int cntWidth(input int numChunks);
    return (numChunks > 1) ? $clog2(numChunks) : 1;
  endfunction

endpackage

// File: rtl/partial_sum_sequencer_adder_tree.sv
// Combinational adder tree. It reduces NUM_NODES packed addends to a single
// sum. All arithmetic wraps modulo 2^PRECISION_BITS.
//
// Ports:
//   i_addends - NUM_NODES packed words; node i is at [i*PRECISION_BITS +: PRECISION_BITS]
//   o_sum     - wrapped sum of all nodes
module partial_sum_sequencer_adder_tree #(
  parameter int PRECISION_BITS = 8,
  parameter int NUM_NODES      = 4
) (
  input  logic [PRECISION_BITS*NUM_NODES-1:0] i_addends,
  output logic [PRECISION_BITS-1:0]           o_sum
);

  logic [PRECISION_BITS-1:0] w_lvl [NUM_NODES];

  // The reduction works in place, pairwise. At each level, element i absorbs
  // element i+step. This gives a log2(NUM_NODES)-deep tree, because NUM_NODES
  // is a power of 2.
  always_comb begin
    for (int i = 0; i < NUM_NODES; i++) begin
      w_lvl[i] = i_addends[i*PRECISION_BITS +: PRECISION_BITS];
    end
    for (int step = 1; step < NUM_NODES; step = step * 2) begin
      for (int i = 0; i + step < NUM_NODES; i = i + 2 * step) begin
        w_lvl[i] = w_lvl[i] + w_lvl[i+step];
      end
    end
    o_sum = w_lvl[0];
  end

endmodule

// File: rtl/partial_sum_sequencer.sv
// Partial-sum sequencer. Each accepted beat of NUM_NODES addends is reduced
// by an adder tree and accumulated. After NUM_CHUNKS beats, the total is
// presented on out_sum and held until the consumer takes it.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - input beat handshake; in_data carries packed addends
//   clear               - synchronous abort; returns the block to IDLE
//   out_valid/out_ready - result handshake; out_sum holds the result
//   busy                - high whenever the FSM is not in IDLE
module partial_sum_sequencer
  import partial_sum_sequencer_pkg::*;
#(
  parameter int PRECISION_BITS = 8,
  parameter int NUM_NODES      = 4,
  parameter int NUM_CHUNKS     = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [PRECISION_BITS*NUM_NODES-1:0] in_data,
  input  logic                                clear,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [PRECISION_BITS-1:0]           out_sum,
  output logic                                busy
);

  localparam int CNT_W = cntWidth(NUM_CHUNKS);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  seqState_t                 r_state;
  logic [PRECISION_BITS-1:0] r_acc;
  logic [CNT_W-1:0]          r_cnt;
  logic [PRECISION_BITS-1:0] r_outSum;
  logic                      r_outValid;

  logic [PRECISION_BITS-1:0] w_treeSum;
  logic [PRECISION_BITS-1:0] w_accNext;

  partial_sum_sequencer_adder_tree #(
    .PRECISION_BITS(PRECISION_BITS),
    .NUM_NODES     (NUM_NODES)
  ) u_adder_tree (
    .i_addends(in_data),
    .o_sum    (w_treeSum)
  );

  assign w_accNext = r_acc + w_treeSum;

  assign in_ready  = (r_state != HOLD);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_outValid;
  assign out_sum   = r_outSum;

  // In IDLE and ACCUM, in_ready is 1, so in_valid alone marks an accepted
  // beat there. The accumulator and counter are zeroed on the final beat.
  // This leaves IDLE clean after the result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_outSum   <= '0;
      r_outValid <= 1'b0;
    end else if (clear) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_outSum   <= '0;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (in_valid) begin
            if (r_cnt == LAST_CHUNK) begin
              r_state    <= HOLD;
              r_outSum   <= w_accNext;
              r_outValid <= 1'b1;
              r_acc      <= '0;
              r_cnt      <= '0;
            end else begin
              r_state <= ACCUM;
              r_acc   <= w_accNext;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_acc      <= '0;
          r_cnt      <= '0;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_partial_sum_sequencer.sv
// Testbench for partial_sum_sequencer using directed beats. The expected
// results are queued when the stimulus is issued. A monitor pops the queue
// and compares on every result handshake, and checks that out_sum is stable
// while the result is held.
module tb_partial_sum_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_sum;
  logic        busy;

  int checkCount = 0;
  int passCount  = 0;
  logic [7:0] expQ[$];

  partial_sum_sequencer #(
    .PRECISION_BITS(8),
    .NUM_NODES     (4),
    .NUM_CHUNKS    (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .clear    (clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one value against its expected value and counts the result.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Presents one beat and holds it until a rising edge accepts it. After
  // that, it optionally inserts bubble cycles.
  task automatic applyStimulus(input logic [31:0] data, input int bubbles);
    in_data  = data;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (bubbles > 0) begin
      in_valid = 1'b0;
      repeat (bubbles) @(posedge clk);
      #1;
    end
  endtask

  // Sends four beats with every node equal to val, back to back, and queues
  // the expected result. It then checks that the result appears one cycle
  // after the last beat.
  task automatic runResult(input logic [7:0] val, input logic [7:0] expSum, input string name);
    expQ.push_back(expSum);
    for (int k = 0; k < 4; k++) applyStimulus({val, val, val, val}, 0);
    in_valid = 1'b0;
    checkOutput({name, "_validLatency"}, 32'(out_valid), 32'd1);
    checkOutput({name, "_readyInHold"}, 32'(in_ready), 32'd0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedResult", 32'(out_sum), 32'hFFFF_FFFF);
      end else if (out_ready) begin
        checkOutput("resultSum", 32'(out_sum), 32'(expQ.pop_front()));
      end else begin
        checkOutput("holdSumStable", 32'(out_sum), 32'(expQ[0]));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] b;
    int waitCycles;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    out_ready = 1'b1;

    // Check the reset state.
    #3;
    checkOutput("rstInReady", 32'(in_ready), 32'd1);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstOutSum", 32'(out_sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Four back-to-back beats of 0x01.
    runResult(8'h01, 8'h10, "ones");
    @(posedge clk); #1;
    checkOutput("ones_validDrop", 32'(out_valid), 32'd0);
    checkOutput("ones_idle", 32'(busy), 32'd0);

    // Four beats of 0xFF wrap to 0xF0.
    runResult(8'hFF, 8'hF0, "wrap");
    @(posedge clk); #1;
    checkOutput("wrap_idle", 32'(busy), 32'd0);

    // Beats 1..4 with bubbles in between; the consumer stalls for 3 cycles.
    out_ready = 1'b0;
    expQ.push_back(8'h28);
    for (int k = 1; k <= 4; k++) begin
      b = 8'(k);
      applyStimulus({b, b, b, b}, (k < 4) ? 2 : 0);
      if (k == 1) checkOutput("bubble_busy", 32'(busy), 32'd1);
    end
    in_valid = 1'b0;
    checkOutput("bubble_validLatency", 32'(out_valid), 32'd1);
    repeat (3) begin
      checkOutput("hold_inReady", 32'(in_ready), 32'd0);
      checkOutput("hold_outValid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("hold_release_idle", 32'(busy), 32'd0);
    checkOutput("hold_release_valid", 32'(out_valid), 32'd0);
    checkOutput("hold_release_ready", 32'(in_ready), 32'd1);

    // Reset in mid-accumulation. The first beat is already valid when reset
    // is released.
    applyStimulus(32'h0101_0101, 0);
    applyStimulus(32'h0101_0101, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midReset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    expQ.push_back(8'h20);
    in_data  = 32'h0202_0202;
    in_valid = 1'b1;
    rst_n    = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(32'h0202_0202, 0);
    in_valid = 1'b0;
    checkOutput("midReset_validLatency", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Clear is asserted together with beat 3. That beat is discarded.
    applyStimulus(32'h0101_0101, 0);
    applyStimulus(32'h0101_0101, 0);
    clear = 1'b1;
    applyStimulus(32'h0505_0505, 0);
    clear = 1'b0;
    in_valid = 1'b0;
    checkOutput("clear_idle", 32'(busy), 32'd0);
    checkOutput("clear_outSum", 32'(out_sum), 32'd0);
    runResult(8'h01, 8'h10, "afterClear");
    @(posedge clk); #1;

    // out_ready is held high across two consecutive results.
    runResult(8'h03, 8'h30, "pulseA");
    @(posedge clk); #1;
    checkOutput("pulseA_oneCycle", 32'(out_valid), 32'd0);
    runResult(8'h04, 8'h40, "pulseB");
    @(posedge clk); #1;
    checkOutput("pulseB_oneCycle", 32'(out_valid), 32'd0);

    // Every queued result must have been consumed.
    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
